// File: rtl/xdrop_extender_pkg.sv
// Shared Blastn definitions: extender FSM states, 2-bit base codes and the
// default scoring constants.
package xdrop_extender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  localparam int DEF_MATCH    = 2;
  localparam int DEF_MISMATCH = -1;
  localparam int DEF_XDROP    = 10;

endpackage

// File: rtl/xdrop_extender_if.sv
// Pair stream in, result out. Both sides use valid/ready: a transfer happens
// on a rising edge where valid and ready are both high; valid never waits on ready.
interface xdrop_extender_if #(
  parameter int SCORE_W = 16,
  parameter int LEN_W   = 16
);
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                q_base;
  logic [1:0]                s_base;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [SCORE_W-1:0] best_score;
  logic [LEN_W-1:0]          best_len;
  logic                      drop_hit;

  modport master (
    output start, in_valid, q_base, s_base, in_last, out_ready,
    input  in_ready, out_valid, best_score, best_len, drop_hit
  );

  modport slave (
    input  start, in_valid, q_base, s_base, in_last, out_ready,
    output in_ready, out_valid, best_score, best_len, drop_hit
  );
endinterface

// File: rtl/xdrop_extender_score_step.sv
// One beat of the running score: compare bases, pick the award, add it with
// saturation at the signed SCORE_W limits. Purely combinational.
module xdrop_extender_score_step #(
  parameter int SCORE_W  = 16,
  parameter int MATCH    = 2,
  parameter int MISMATCH = -1
) (
  input  logic [1:0]                q_base,
  input  logic [1:0]                s_base,
  input  logic signed [SCORE_W-1:0] score,
  output logic signed [SCORE_W-1:0] new_score
);
  localparam int XW = SCORE_W + 1;
  localparam logic signed [XW-1:0] MATCH_X    = XW'(MATCH);
  localparam logic signed [XW-1:0] MISMATCH_X = XW'(MISMATCH);
  localparam logic signed [XW-1:0] S_MAX      = XW'((1 << (SCORE_W - 1)) - 1);
  localparam logic signed [XW-1:0] S_MIN      = XW'(-(1 << (SCORE_W - 1)));

  logic signed [XW-1:0] award;
  logic signed [XW-1:0] sum;

  always_comb begin
    award = (q_base == s_base) ? MATCH_X : MISMATCH_X;
    sum   = {score[SCORE_W-1], score} + award;
    if (sum > S_MAX)      new_score = S_MAX[SCORE_W-1:0];
    else if (sum < S_MIN) new_score = S_MIN[SCORE_W-1:0];
    else                  new_score = sum[SCORE_W-1:0];
  end
endmodule

// File: rtl/xdrop_extender.sv
// Ungapped X-drop extension: accumulates a running score one base pair per
// cycle and reports the best score and the length at which it first occurred.
module xdrop_extender
  import xdrop_extender_pkg::*;
#(
  parameter int SCORE_W  = 16,
  parameter int LEN_W    = 16,
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int XDROP    = DEF_XDROP
) (
  input  logic                clk,
  input  logic                rst,
  xdrop_extender_if.slave     bus,
  output state_t              state
);
  localparam int XW = SCORE_W + 1;

  state_t                    cur_state, nxt_state;
  logic signed [SCORE_W-1:0] score, best;
  logic [LEN_W-1:0]          pos, best_at;
  logic                      drop;

  logic signed [SCORE_W-1:0] new_score, best_upd;
  logic [LEN_W-1:0]          pos_next;
  logic signed [XW-1:0]      gap;
  logic                      accept, improved, x_drop, pos_sat, finish;

  xdrop_extender_score_step #(
    .SCORE_W (SCORE_W),
    .MATCH   (MATCH),
    .MISMATCH(MISMATCH)
  ) u_step (
    .q_base   (bus.q_base),
    .s_base   (bus.s_base),
    .score    (score),
    .new_score(new_score)
  );

  always_comb begin
    accept   = (cur_state == ST_RUN) && bus.in_valid;
    improved = new_score > best;
    best_upd = improved ? new_score : best;
    // gap is never negative: best_upd already includes new_score
    gap      = {best_upd[SCORE_W-1], best_upd} - {new_score[SCORE_W-1], new_score};
    x_drop   = gap >= XW'(XDROP);
    pos_next = pos + 1'b1;
    pos_sat  = pos_next == {LEN_W{1'b1}};
    finish   = accept && (x_drop || bus.in_last || pos_sat);
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE: if (bus.start)     nxt_state = ST_RUN;
      ST_RUN:  if (finish)        nxt_state = ST_DONE;
      ST_DONE: if (bus.out_ready) nxt_state = ST_IDLE;
      default:                    nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_IDLE;
      score     <= '0;
      pos       <= '0;
      best      <= '0;
      best_at   <= '0;
      drop      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == ST_IDLE && bus.start) begin
        score   <= '0;
        pos     <= '0;
        best    <= '0;
        best_at <= '0;
        drop    <= 1'b0;
      end else if (accept) begin
        score <= new_score;
        pos   <= pos_next;
        if (improved) begin
          best    <= new_score;
          best_at <= pos_next;
        end
        if (finish) drop <= x_drop;
      end
    end
  end

  assign bus.in_ready   = (cur_state == ST_RUN);
  assign bus.out_valid  = (cur_state == ST_DONE);
  assign bus.best_score = best;
  assign bus.best_len   = best_at;
  assign bus.drop_hit   = drop;
  assign state          = cur_state;
endmodule

// File: tb/tb_xdrop_extender.sv
// Bench for xdrop_extender with MATCH=2, MISMATCH=-1, XDROP=3, narrow widths
// so score and length saturation are reachable.
module tb_xdrop_extender;
  import xdrop_extender_pkg::*;

  localparam int SCORE_W = 7;
  localparam int LEN_W   = 6;
  localparam int P_MATCH = 2;
  localparam int P_MIS   = -1;
  localparam int P_XDROP = 3;
  localparam int S_MAX   = 63;
  localparam int S_MIN   = -64;
  localparam int POS_MAX = 63;

  // clock / reset
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  always #5 clk = ~clk;

  xdrop_extender_if #(.SCORE_W(SCORE_W), .LEN_W(LEN_W)) bus ();

  xdrop_extender #(
    .SCORE_W (SCORE_W),
    .LEN_W   (LEN_W),
    .MATCH   (P_MATCH),
    .MISMATCH(P_MIS),
    .XDROP   (P_XDROP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] q_arr[80];
  logic [1:0] s_arr[80];

  typedef struct {
    int         n;
    logic [15:0] mask;
    int         exp_best;
    int         exp_len;
    int         exp_drop;
    int         exp_acc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int got_best();
    return int'($signed(bus.best_score));
  endfunction

  // reference: walk the pair list with plain integer arithmetic
  function automatic void model(input int n, input bit use_last, output int best,
                                output int len, output int drop, output int acc);
    int sc;
    sc = 0; best = 0; len = 0; drop = 0; acc = 0;
    for (int i = 0; i < n; i++) begin
      sc += (q_arr[i] == s_arr[i]) ? P_MATCH : P_MIS;
      if (sc > S_MAX) sc = S_MAX;
      if (sc < S_MIN) sc = S_MIN;
      acc = i + 1;
      if (sc > best) begin
        best = sc;
        len  = i + 1;
      end
      if (best - sc >= P_XDROP) begin
        drop = 1;
        return;
      end
      if ((use_last && i == n - 1) || acc == POS_MAX) return;
    end
  endfunction

  task automatic fill_pair(input int i, input bit is_match);
    q_arr[i] = 2'($urandom_range(0, 3));
    s_arr[i] = is_match ? q_arr[i] : 2'((int'(q_arr[i]) + $urandom_range(1, 3)) % 4);
  endtask

  // driver: start, stream pairs until the DUT leaves RUN, report pairs accepted
  task automatic run_ext(input int n, input bit use_last, input bit gaps, output int acc);
    bit take;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 400 && acc < n; cyc++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.q_base   = 2'($urandom_range(0, 3));
        bus.s_base   = 2'($urandom_range(0, 3));
        bus.in_last  = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b1;
        bus.q_base   = q_arr[acc];
        bus.s_base   = s_arr[acc];
        bus.in_last  = use_last && (acc == n - 1);
      end
      take = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (take) acc++;
      if (!bus.in_ready) break;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input int eb, input int el,
                              input int ed, input int ea, input int acc);
    check({tag, "_out_valid"}, int'(bus.out_valid), 1);
    check({tag, "_in_ready"},  int'(bus.in_ready), 0);
    check({tag, "_best"},      got_best(), eb);
    check({tag, "_len"},       int'(bus.best_len), el);
    check({tag, "_drop"},      int'(bus.drop_hit), ed);
    check({tag, "_accepted"},  acc, ea);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle_valid"}, int'(bus.out_valid), 0);
    check({tag, "_idle_state"}, int'(dbg_state), int'(ST_IDLE));
  endtask

  initial begin
    int acc, eb, el, ed, ea, n;
    int hold_best, hold_len, hold_drop;

    vecs[0] = '{n: 4, mask: 16'h000F, exp_best: 8, exp_len: 4, exp_drop: 0, exp_acc: 4};
    vecs[1] = '{n: 8, mask: 16'h0007, exp_best: 6, exp_len: 3, exp_drop: 1, exp_acc: 6};
    vecs[2] = '{n: 4, mask: 16'h0009, exp_best: 2, exp_len: 1, exp_drop: 0, exp_acc: 4};
    vecs[3] = '{n: 4, mask: 16'h0001, exp_best: 2, exp_len: 1, exp_drop: 1, exp_acc: 4};
    vecs[4] = '{n: 3, mask: 16'h0000, exp_best: 0, exp_len: 0, exp_drop: 1, exp_acc: 3};
    vecs[5] = '{n: 1, mask: 16'h0001, exp_best: 2, exp_len: 1, exp_drop: 0, exp_acc: 1};
    vecs[6] = '{n: 3, mask: 16'h0006, exp_best: 3, exp_len: 3, exp_drop: 0, exp_acc: 3};

    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.q_base = BASE_A; bus.s_base = BASE_A; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_state",     int'(dbg_state), int'(ST_IDLE));
    check("rst_in_ready",  int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_best",      got_best(), 0);
    check("rst_len",       int'(bus.best_len), 0);
    check("rst_drop",      int'(bus.drop_hit), 0);

    // directed table
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].n; i++) fill_pair(i, vecs[v].mask[i]);
      run_ext(vecs[v].n, 1'b1, 1'b0, acc);
      check_result($sformatf("vec%0d", v), vecs[v].exp_best, vecs[v].exp_len,
                   vecs[v].exp_drop, vecs[v].exp_acc, acc);
      release_result($sformatf("vec%0d", v));
    end

    // backpressure with start pulsed while DONE, then outputs held in IDLE
    for (int i = 0; i < 4; i++) fill_pair(i, 1'b1);
    run_ext(4, 1'b1, 1'b0, acc);
    check_result("bp", 8, 4, 0, 4, acc);
    for (int c = 0; c < 5; c++) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", c), int'(bus.out_valid), 1);
      check($sformatf("bp%0d_state", c), int'(dbg_state), int'(ST_DONE));
      check($sformatf("bp%0d_best", c),  got_best(), 8);
      check($sformatf("bp%0d_len", c),   int'(bus.best_len), 4);
      check($sformatf("bp%0d_drop", c),  int'(bus.drop_hit), 0);
    end
    bus.start = 1'b0;
    release_result("bp");
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_best", got_best(), 8);
    check("idle_hold_len",  int'(bus.best_len), 4);

    // length saturation: all matches, no in_last; score also clips at 63
    for (int i = 0; i < 70; i++) fill_pair(i, 1'b1);
    run_ext(70, 1'b0, 1'b0, acc);
    check_result("sat", 63, 32, 0, 63, acc);
    release_result("sat");

    // reset after two accepted pairs discards the extension
    for (int i = 0; i < 8; i++) fill_pair(i, 1'b1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.q_base = q_arr[0]; bus.s_base = s_arr[0];
    @(posedge clk); #1;
    bus.q_base = q_arr[1]; bus.s_base = s_arr[1];
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_in_ready",  int'(bus.in_ready), 0);
    check("mrst_out_valid", int'(bus.out_valid), 0);
    check("mrst_best",      got_best(), 0);
    check("mrst_state",     int'(dbg_state), int'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1;
    check("mrst_no_result", int'(bus.out_valid), 0);
    fill_pair(0, 1'b1);
    run_ext(1, 1'b1, 1'b0, acc);
    check_result("mrst_new", 2, 1, 0, 1, acc);
    release_result("mrst_new");

    // randomized runs with input bubbles against the reference model
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) fill_pair(i, $urandom_range(0, 9) < 7);
      model(n, 1'b1, eb, el, ed, ea);
      run_ext(n, 1'b1, 1'b1, acc);
      check_result($sformatf("rnd%0d", r), eb, el, ed, ea, acc);
      if ($urandom_range(0, 1) == 1) begin
        hold_best = got_best(); hold_len = int'(bus.best_len); hold_drop = int'(bus.drop_hit);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        check($sformatf("rnd%0d_hold", r), got_best() * 1000 + int'(bus.best_len) * 2 + int'(bus.drop_hit),
              hold_best * 1000 + hold_len * 2 + hold_drop);
      end
      release_result($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
